// File: rtl/nfa_accept_samples_generic_hw_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nfa_accept_samples_generic_hw_mul_arbiter
// Brief    : Shares one external pipelined unsigned multiplier among NREQ
//            requesters. Grants at most one operation per cycle, carries
//            {valid, id} alongside the multiplier pipeline, and returns
//            products on a single valid/ready result channel. Result
//            backpressure freezes the multiplier through mul_ce.
// Options  : MUL_ARB_FIXED_PRIO_EN - when defined, the lowest requester index
//            always wins and the round-robin pointer is removed.
//            Default (undefined) is round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module nfa_accept_samples_generic_hw_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2,
  parameter int A_W  = 8,
  parameter int B_W  = 6,
  parameter int P_W  = 14,
  parameter int LAT  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*A_W-1:0]   req_a,
  input  logic [NREQ*B_W-1:0]   req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  mul_ce,
  output logic [A_W-1:0]        mul_a,
  output logic [B_W-1:0]        mul_b,
  input  logic [P_W-1:0]        mul_p,
  output logic                  res_valid,
  output logic [ID_W-1:0]       res_id,
  output logic [P_W-1:0]        res_p,
  input  logic                  res_ready,
  output logic                  busy
);

  localparam int c_cnt_w = $clog2(LAT + 1);

  // Tracking pipe mirrors the multiplier stages; the tail is the result.
  logic [LAT-1:0]     r_vld;
  logic [ID_W-1:0]    r_id [LAT];
  logic [c_cnt_w-1:0] r_in_flight;

  logic               w_stall;
  logic               w_grant_any;
  logic [ID_W-1:0]    w_grant_id;
  logic [ID_W-1:0]    w_idx;
  logic               w_accept;
  logic               w_res_hs;

`ifndef MUL_ARB_FIXED_PRIO_EN
  localparam logic [ID_W:0] c_nreq = (ID_W+1)'(NREQ);
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_next_ptr;
`endif

  // A held result at the tail freezes the whole pipe, multiplier included.
  assign w_stall   = r_vld[LAT-1] & ~res_ready;
  assign mul_ce    = ~w_stall;
  assign w_accept  = w_grant_any & ~w_stall;
  assign w_res_hs  = r_vld[LAT-1] & res_ready;

  assign res_valid = r_vld[LAT-1];
  assign res_id    = r_id[LAT-1];
  assign res_p     = mul_p;
  assign busy      = (r_in_flight != '0);

  // Arbitration: scan downward so the candidate nearest the start point wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_idx       = '0;
`ifndef MUL_ARB_FIXED_PRIO_EN
    w_sum       = '0;
`endif
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
      w_idx = ID_W'(k);
`else
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_sum >= c_nreq) begin
        w_sum = w_sum - c_nreq;
      end
      w_idx = w_sum[ID_W-1:0];
`endif
      if (req_valid[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant_id  = w_idx;
      end
    end
  end

  // One-hot ready and operand steering; zero operands when nothing is accepted.
  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_accept && (w_grant_id == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        mul_a        = req_a[i*A_W +: A_W];
        mul_b        = req_b[i*B_W +: B_W];
      end
    end
  end

`ifndef MUL_ARB_FIXED_PRIO_EN
  assign w_next_ptr = (w_grant_id == ID_W'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;

  // Round-robin pointer moves just past the requester that was served.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_next_ptr;
    end
  end
`endif

  // Tracking pipe advances in lockstep with the multiplier clock enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_id[i] <= '0;
      end
    end else if (mul_ce) begin
      r_vld   <= {r_vld[LAT-2:0], w_accept};
      r_id[0] <= w_grant_id;
      for (int i = 1; i < LAT; i++) begin
        r_id[i] <= r_id[i-1];
      end
    end
  end

  // Outstanding operation count: accepted but not yet handed downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_flight <= '0;
    end else begin
      case ({w_accept, w_res_hs})
        2'b10:   r_in_flight <= r_in_flight + 1'b1;
        2'b01:   r_in_flight <= r_in_flight - 1'b1;
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nfa_accept_samples_generic_hw_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nfa_accept_samples_generic_hw_mul_arbiter
// Brief    : Directed self-checking bench with a behavioural pipelined
//            multiplier and a result scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nfa_accept_samples_generic_hw_mul_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int A_W  = 8;
  localparam int B_W  = 6;
  localparam int P_W  = 14;
  localparam int LAT  = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic [NREQ-1:0]     req_ready;
  logic                mul_ce;
  logic [A_W-1:0]      mul_a;
  logic [B_W-1:0]      mul_b;
  logic [P_W-1:0]      mul_p;
  logic                res_valid;
  logic [ID_W-1:0]     res_id;
  logic [P_W-1:0]      res_p;
  logic                res_ready;
  logic                busy;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [P_W-1:0]  p;
    int              cyc;
    bit              lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   exp_ptr  = 0;
  int   op_a [NREQ];
  int   op_b [NREQ];

  always #5 clk = ~clk;

  nfa_accept_samples_generic_hw_mul_arbiter #(
    .NREQ(NREQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W), .LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_ce(mul_ce), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .res_valid(res_valid), .res_id(res_id), .res_p(res_p), .res_ready(res_ready),
    .busy(busy)
  );

  // Behavioural multiplier: input register plus output stages, ce-gated, no reset.
  logic [P_W-1:0] m_pipe [LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      m_pipe[0] <= P_W'(mul_a) * P_W'(mul_b);
      for (int i = 1; i < LAT; i++) m_pipe[i] <= m_pipe[i-1];
    end
  end
  assign mul_p = m_pipe[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Arbitration reference; in fixed-priority builds exp_ptr is never moved off 0.
  function automatic int exp_grant(input logic [NREQ-1:0] m, input int ptr);
    int i;
    for (int k = 0; k < NREQ; k++) begin
      i = (ptr + k) % NREQ;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*A_W +: A_W] = A_W'(op_a[i]);
      req_b[i*B_W +: B_W] = B_W'(op_b[i]);
    end
  endtask

  // Present one cycle of requests, check the grant and record the expected result.
  task automatic issue(input logic [NREQ-1:0] mask, input bit lat);
    int   g;
    exp_t e;
    req_valid = mask;
    @(negedge clk);
    g = exp_grant(mask, exp_ptr);
    if (g >= 0) begin
      check("grant", 32'(req_ready), 32'(1) << g);
      e.id  = ID_W'(g);
      e.p   = P_W'(op_a[g] * op_b[g]);
      e.cyc = cyc + LAT;
      e.lat = lat;
      sb.push_back(e);
`ifndef MUL_ARB_FIXED_PRIO_EN
      exp_ptr = (g + 1) % NREQ;
`endif
    end else begin
      check("no_grant", 32'(req_ready), 32'd0);
    end
    check("issue_ce", 32'(mul_ce), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: every completed handshake must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("extra_result", 32'(res_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("res_id", 32'(res_id), 32'(e.id));
        check("res_p", 32'(res_p), 32'(e.p));
        if (e.lat) check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int n;
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mul_ce", 32'(mul_ce), 32'd1);
    @(posedge clk); #1;

    // Single operation from requester 0
    op_a = '{200, 10, 20, 255};
    op_b = '{50, 3, 7, 63};
    set_ops();
    issue(4'b0001, 1'b1);
    check("busy_rise", 32'(busy), 32'd1);
    wait_drain(3 * LAT);
    check("busy_fall", 32'(busy), 32'd0);

    // Maximum operands from requester 3
    issue(4'b1000, 1'b1);
    wait_drain(3 * LAT);

    // All requesters valid for eight back-to-back cycles
    op_a = '{17, 57, 97, 137};
    op_b = '{9, 22, 35, 48};
    set_ops();
    for (int i = 0; i < 8; i++) issue(4'b1111, 1'b1);
    wait_drain(4 * LAT);
    check("busy_idle", 32'(busy), 32'd0);

    // Backpressure: hold the tail result for five cycles
    op_a = '{33, 44, 155, 201};
    op_b = '{61, 2, 17, 40};
    set_ops();
    for (int i = 0; i < 4; i++) issue(4'b1111, 1'b0);
    res_ready = 1'b0;
    n = 0;
    while (!res_valid && n < 3 * LAT) begin
      @(posedge clk); #1;
      n++;
    end
    check("valid_timeout", 32'(res_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b1111;
      @(negedge clk);
      check("stall_ce", 32'(mul_ce), 32'd0);
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_valid", 32'(res_valid), 32'd1);
      check("stall_id", 32'(res_id), 32'(sb[0].id));
      check("stall_p", 32'(res_p), 32'(sb[0].p));
      check("stall_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    req_valid = '0;
    res_ready = 1'b1;
    wait_drain(3 * LAT);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_stall_idle", 32'(res_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Reset with three operations in flight
    op_a = '{5, 6, 7, 8};
    op_b = '{9, 10, 11, 12};
    set_ops();
    for (int i = 0; i < 3; i++) issue(4'b0010, 1'b1);
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset   = 1'b0;
    exp_ptr = 0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      check("mid_rst_no_valid", 32'(res_valid), 32'd0);
    end
    @(posedge clk); #1;
    issue(4'b1111, 1'b1);
    issue(4'b0100, 1'b1);
    wait_drain(3 * LAT);
    check("mid_rst_busy_end", 32'(busy), 32'd0);

    // Requesters 1 and 3 contending, then requester 3 alone
    for (int i = 0; i < 4; i++) issue(4'b1010, 1'b1);
    issue(4'b1000, 1'b1);
    wait_drain(3 * LAT);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
